btb_update_ctrl: RTL and testbench

- Sits between the execute-stage branch resolution logic and the branch target buffer. Owns the BTB write port.
- Filters resolved branches and keeps only the ones that need a BTB write: taken branches that either missed in the BTB or were predicted with the wrong target.
- Buffers those writes in a small FIFO. Drains the FIFO into the BTB only in cycles where fetch is not stalled, so the BTB's update gate never silently drops a write.

---
 rtl/btb_pkg.sv | 30 +++
 rtl/btb_update_ctrl_if.sv | 29 ++
 rtl/btb_upd_fifo.sv | 57 +++++
 rtl/btb_update_ctrl.sv | 103 ++++++++++
 tb/tb_btb_update_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/btb_pkg.sv
// Shared types and field helpers for the BTB update path.
// Address widths are fixed here so the entry struct has one definition.
package btb_pkg;
   localparam int ADDR_WIDTH        = 64;
   localparam int INDEX_WIDTH       = 2;
   localparam int BYTE_OFFSET_WIDTH = 2;
   localparam int BIA_WIDTH         = ADDR_WIDTH - INDEX_WIDTH - BYTE_OFFSET_WIDTH;
   localparam int N                 = 4;
   localparam int WAY_WIDTH         = $clog2(N);

   typedef struct packed {
      logic [BIA_WIDTH-1:0]   bia;
      logic [INDEX_WIDTH-1:0] index;
      logic [WAY_WIDTH-1:0]   way;
      logic [ADDR_WIDTH-1:0]  target;
   } btb_upd_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_DRAIN = 1'b1
   } ctrl_state_t;

   function automatic logic [BIA_WIDTH-1:0] get_bia(input logic [ADDR_WIDTH-1:0] pc);
      return pc[ADDR_WIDTH-1 -: BIA_WIDTH];
   endfunction

   function automatic logic [INDEX_WIDTH-1:0] get_index(input logic [ADDR_WIDTH-1:0] pc);
      return pc[INDEX_WIDTH+BYTE_OFFSET_WIDTH-1 : BYTE_OFFSET_WIDTH];
   endfunction
endpackage

// File: rtl/btb_update_ctrl_if.sv
// Resolution bus in, BTB write port out.
// The controller takes the slave side; the resolution/BTB environment takes the master side.
interface btb_update_ctrl_if;
   import btb_pkg::*;

   logic                   res_valid;
   logic                   res_taken;
   logic [ADDR_WIDTH-1:0]  res_pc;
   logic [ADDR_WIDTH-1:0]  res_target;
   logic                   res_btb_hit;
   logic [ADDR_WIDTH-1:0]  res_pred_target;
   logic [WAY_WIDTH-1:0]   res_way;

   logic                   btb_write;
   logic [ADDR_WIDTH-1:0]  btb_target;
   logic [BIA_WIDTH-1:0]   btb_bia;
   logic [INDEX_WIDTH-1:0] btb_index;
   logic [WAY_WIDTH-1:0]   btb_way;

   modport master (
      output res_valid, res_taken, res_pc, res_target, res_btb_hit, res_pred_target, res_way,
      input  btb_write, btb_target, btb_bia, btb_index, btb_way
   );

   modport slave (
      input  res_valid, res_taken, res_pc, res_target, res_btb_hit, res_pred_target, res_way,
      output btb_write, btb_target, btb_bia, btb_index, btb_way
   );
endinterface

// File: rtl/btb_upd_fifo.sv
// Circular FIFO of pending BTB updates with in-place tail overwrite.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module btb_upd_fifo
   import btb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     i_clk,
   input  logic     i_arst,
   input  logic     push,
   input  logic     pop,
   input  logic     flush,
   input  logic     overwrite_tail,
   input  btb_upd_t din,
   output logic     full,
   output logic     empty,
   output logic     one,
   output btb_upd_t head,
   output btb_upd_t tail
);
   localparam int PW = $clog2(DEPTH);

   logic [PW:0] wr_ptr;
   logic [PW:0] rd_ptr;
   logic [PW:0] tail_ptr;
   btb_upd_t    mem [DEPTH];

   assign tail_ptr = wr_ptr - (PW+1)'(1);
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign one      = ((wr_ptr - rd_ptr) == (PW+1)'(1));
   assign head     = mem[rd_ptr[PW-1:0]];
   assign tail     = mem[tail_ptr[PW-1:0]];

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
      end
   end

   // Storage is intentionally not reset; contents are only visible while non-empty.
   always_ff @(posedge i_clk) begin
      if (!flush) begin
         if (push)
            mem[wr_ptr[PW-1:0]] <= din;
         else if (overwrite_tail)
            mem[tail_ptr[PW-1:0]] <= din;
      end
   end
endmodule

// File: rtl/btb_update_ctrl.sv
// Filters resolved branches into BTB writes, queues them, and drains only when fetch is not stalled.
//
// state    | meaning
// ST_IDLE  | queue empty, no BTB write requested
// ST_DRAIN | queue holds entries, head presented to the BTB every cycle
module btb_update_ctrl
   import btb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              i_clk,
   input  logic              i_arst,
   input  logic              i_stall_fetch,
   input  logic              i_flush,
   btb_update_ctrl_if.slave  bus,
   output logic              o_full,
   output logic [7:0]        o_drop_cnt
);
   btb_upd_t    res_entry;
   btb_upd_t    head;
   btb_upd_t    tail;
   logic        full;
   logic        empty;
   logic        one;
   logic        need_upd;
   logic        pop;
   logic        push_cand;
   logic        tail_hazard;
   logic        overwrite;
   logic        push;
   logic        drop;
   ctrl_state_t state;
   ctrl_state_t state_nxt;

   assign res_entry = '{bia:    get_bia(bus.res_pc),
                        index:  get_index(bus.res_pc),
                        way:    bus.res_way,
                        target: bus.res_target};

   assign need_upd  = bus.res_valid & bus.res_taken &
                      (~bus.res_btb_hit | (bus.res_pred_target != bus.res_target));
   assign pop       = ~empty & ~i_stall_fetch;
   assign push_cand = need_upd & (~full | pop) & ~i_flush;

   // A newer write to the same set/way would clobber the queued tail anyway, so replace it.
   assign tail_hazard = ~empty & ~(pop & one) &
                        (tail.index == res_entry.index) &
                        (tail.way   == res_entry.way) &
                        (tail.bia   != res_entry.bia);
   assign overwrite   = push_cand & tail_hazard;
   assign push        = push_cand & ~tail_hazard;
   assign drop        = need_upd & full & ~pop & ~i_flush;

   btb_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .i_clk          (i_clk),
      .i_arst         (i_arst),
      .push           (push),
      .pop            (pop),
      .flush          (i_flush),
      .overwrite_tail (overwrite),
      .din            (res_entry),
      .full           (full),
      .empty          (empty),
      .one            (one),
      .head           (head),
      .tail           (tail)
   );

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (push) state_nxt = ST_DRAIN;
         ST_DRAIN: if (i_flush || (pop && one && !push)) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.btb_write = 1'b0;
      case (state)
         ST_DRAIN: bus.btb_write = 1'b1;
         default:  bus.btb_write = 1'b0;
      endcase
   end

   assign bus.btb_target = head.target;
   assign bus.btb_bia    = head.bia;
   assign bus.btb_index  = head.index;
   assign bus.btb_way    = head.way;
   assign o_full         = full;

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst)
         o_drop_cnt <= '0;
      else if (drop && (o_drop_cnt != 8'hFF))
         o_drop_cnt <= o_drop_cnt + 8'd1;
   end
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed and random stimulus against a queue-based reference of the update buffer.
module tb_btb_update_ctrl;
   import btb_pkg::*;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       arst;
   logic       stall;
   logic       flush;
   logic       full;
   logic [7:0] drop;

   btb_update_ctrl_if ifc ();

   btb_update_ctrl #(.DEPTH(DEPTH)) dut (
      .i_clk         (clk),
      .i_arst        (arst),
      .i_stall_fetch (stall),
      .i_flush       (flush),
      .bus           (ifc.slave),
      .o_full        (full),
      .o_drop_cnt    (drop)
   );

   always #5 clk = ~clk;

   int       checks = 0;
   int       errors = 0;
   btb_upd_t mq[$];
   int       mdrop = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_res(input logic v, input logic t, input logic [63:0] pc,
                          input logic [63:0] tgt, input logic hit,
                          input logic [63:0] pred, input logic [1:0] way);
      ifc.res_valid       = v;
      ifc.res_taken       = t;
      ifc.res_pc          = pc;
      ifc.res_target      = tgt;
      ifc.res_btb_hit     = hit;
      ifc.res_pred_target = pred;
      ifc.res_way         = way;
   endtask

   task automatic idle_res();
      set_res(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 2'd0);
   endtask

   task automatic check_outputs();
      chk("write", ifc.btb_write, mq.size() != 0);
      chk("full", full, mq.size() == DEPTH);
      chk("drop_cnt", drop, mdrop);
      if (mq.size() != 0) begin
         chk("head_bia", ifc.btb_bia, mq[0].bia);
         chk("head_index", ifc.btb_index, mq[0].index);
         chk("head_way", ifc.btb_way, mq[0].way);
         chk("head_target", ifc.btb_target, mq[0].target);
      end
   endtask

   // Reference: queue of pending writes; bia/index are computed by shifting the PC.
   task automatic model_update();
      btb_upd_t e;
      bit       need;
      bit       pop;
      need = ifc.res_valid && ifc.res_taken &&
             (!ifc.res_btb_hit || ifc.res_pred_target != ifc.res_target);
      pop  = (mq.size() > 0) && !stall;
      e.bia    = BIA_WIDTH'(ifc.res_pc >> 4);
      e.index  = INDEX_WIDTH'((ifc.res_pc >> 2) & 64'h3);
      e.way    = ifc.res_way;
      e.target = ifc.res_target;
      if (flush) begin
         mq.delete();
      end else begin
         if (need && (mq.size() < DEPTH || pop)) begin
            if (mq.size() > 0 && !(pop && mq.size() == 1) &&
                mq[$].index == e.index && mq[$].way == e.way && mq[$].bia != e.bia)
               mq[$] = e;
            else
               mq.push_back(e);
         end else if (need) begin
            if (mdrop < 255) mdrop++;
         end
         if (pop) void'(mq.pop_front());
      end
   endtask

   task automatic step();
      @(negedge clk);
      check_outputs();
      model_update();
      @(posedge clk);
      #1;
   endtask

   initial begin
      arst  = 1'b1;
      stall = 1'b0;
      flush = 1'b0;
      idle_res();
      #12;
      chk("rst_write", ifc.btb_write, 1'b0);
      chk("rst_full", full, 1'b0);
      chk("rst_drop", drop, 8'd0);
      @(posedge clk);
      #1;
      arst = 1'b0;

      // Miss fill
      set_res(1, 1, 64'h1008, 64'h2000, 0, 64'h0, 2'd1);
      step();
      idle_res();
      chk("fill_write", ifc.btb_write, 1'b1);
      chk("fill_index", ifc.btb_index, 2);
      chk("fill_bia", ifc.btb_bia, 64'h100);
      chk("fill_way", ifc.btb_way, 1);
      chk("fill_target", ifc.btb_target, 64'h2000);
      step();
      chk("fill_done", ifc.btb_write, 1'b0);

      // Correct prediction and not-taken produce nothing
      set_res(1, 1, 64'h1010, 64'h3000, 1, 64'h3000, 2'd0);
      step();
      set_res(1, 0, 64'h1014, 64'h3000, 0, 64'h0, 2'd0);
      step();
      idle_res();
      chk("nopush_write", ifc.btb_write, 1'b0);
      chk("nopush_drop", drop, 8'd0);

      // Stall retry
      stall = 1'b1;
      set_res(1, 1, 64'h2004, 64'h4444, 0, 64'h0, 2'd2);
      step();
      idle_res();
      for (int i = 0; i < 3; i++) begin
         chk("stall_write", ifc.btb_write, 1'b1);
         chk("stall_target", ifc.btb_target, 64'h4444);
         if (i < 2) step();
      end
      stall = 1'b0;
      step();
      chk("stall_empty", ifc.btb_write, 1'b0);

      // Full and drop under stall
      stall = 1'b1;
      for (int k = 0; k < 5; k++) begin
         set_res(1, 1, 64'h4000 + 64'(4 * (k % 4)) + 64'(16 * k), 64'h5000 + 64'(k), 0, 64'h0, 2'(k));
         step();
         if (k == 3) chk("full_after4", full, 1'b1);
      end
      chk("drop_one", drop, 8'd1);
      set_res(1, 1, 64'h6004, 64'h5006, 0, 64'h0, 2'd0);
      stall = 1'b0;
      step();
      idle_res();
      chk("push_pop_full", full, 1'b1);
      chk("drop_still_one", drop, 8'd1);
      for (int k = 0; k < 4; k++) begin
         chk("drain_order", ifc.btb_target, (k < 3) ? 64'h5001 + 64'(k) : 64'h5006);
         step();
      end
      chk("drained", ifc.btb_write, 1'b0);

      // Tail overwrite
      stall = 1'b1;
      set_res(1, 1, 64'h8000, 64'hA000, 0, 64'h0, 2'd3);
      step();
      set_res(1, 1, 64'h9000, 64'hB000, 0, 64'h0, 2'd3);
      step();
      idle_res();
      chk("ovw_bia", ifc.btb_bia, 64'h900);
      step();
      stall = 1'b0;
      step();
      chk("ovw_one_write", ifc.btb_write, 1'b0);

      // Flush with a same-cycle push
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         set_res(1, 1, 64'hC000 + 64'(4 * k), 64'hD000 + 64'(k), 0, 64'h0, 2'(k));
         step();
      end
      flush = 1'b1;
      set_res(1, 1, 64'hE000, 64'hF000, 0, 64'h0, 2'd1);
      step();
      flush = 1'b0;
      idle_res();
      chk("flush_empty", ifc.btb_write, 1'b0);
      chk("flush_drop", drop, 8'd1);

      // Reset mid-drain
      for (int k = 0; k < 2; k++) begin
         set_res(1, 1, 64'h7000 + 64'(4 * k), 64'h7700 + 64'(k), 0, 64'h0, 2'(k));
         step();
      end
      idle_res();
      stall = 1'b0;
      chk("pre_rst_write", ifc.btb_write, 1'b1);
      arst = 1'b1;
      #1;
      chk("arst_write", ifc.btb_write, 1'b0);
      chk("arst_drop", drop, 8'd0);
      mq.delete();
      mdrop = 0;
      @(posedge clk);
      #1;
      arst = 1'b0;

      // Random traffic against the reference
      for (int c = 0; c < 400; c++) begin
         logic [63:0] pc;
         logic [63:0] tgt;
         pc  = 64'h1000 + 64'($urandom_range(0, 3) << 4) + 64'($urandom_range(0, 3) << 2);
         tgt = 64'h8000 + 64'($urandom_range(0, 7));
         stall = ($urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 24) == 0);
         set_res($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, pc, tgt,
                 $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 1) == 1) ? tgt : tgt + 64'h10,
                 2'($urandom_range(0, 3)));
         step();
      end
      stall = 1'b0;
      flush = 1'b0;
      idle_res();
      for (int c = 0; c < DEPTH + 2; c++) step();
      chk("final_empty", ifc.btb_write, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
